rob_alloc: RTL and testbench

- Dispatch-side allocator and writer for the reorder buffer.
- Each cycle it accepts a packed group of up to DISPATCH_WIDTH instructions and assigns them consecutive ROB indices in program order.
- It writes the new entries (destination register, not-ready) into the ROB's per-column FIFOs, one cycle after acceptance.
- It tracks ROB occupancy from the retire count reported by the ROB, and recovers head/tail on a pipeline flush.

---
 rtl/rob_alloc.sv | 186 ++++++++++++++++++
 tb/tb_rob_alloc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc.sv
// Reorder-buffer dispatch allocator: assigns consecutive ROB indices to a packed
// dispatch group, writes the new entries one cycle later, tracks occupancy and flush recovery.
// Optional stall counter: define ROB_ALLOC_STALL_STATS_EN.
module rob_alloc #(
    parameter int unsigned NUM_ROB_ENTS   = 64,
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned RETIRE_WIDTH   = 4,
    parameter int unsigned AREG_W         = 5,
    localparam int unsigned IDX_W = $clog2(NUM_ROB_ENTS),
    localparam int unsigned CNT_W = IDX_W + 1,
    localparam int unsigned RC_W  = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DISPATCH_WIDTH-1:0]        disp_valid,
    input  logic [DISPATCH_WIDTH*AREG_W-1:0] disp_dst_reg,
    input  logic [DISPATCH_WIDTH-1:0]        disp_has_dst,
    output logic                             disp_ready,
    output logic [DISPATCH_WIDTH*IDX_W-1:0]  alloc_idx,
    output logic [DISPATCH_WIDTH-1:0]        rob_w_en,
    output logic [DISPATCH_WIDTH*IDX_W-1:0]  rob_w_idx,
    output logic [DISPATCH_WIDTH*AREG_W-1:0] rob_w_dst,
    output logic [DISPATCH_WIDTH-1:0]        rob_w_has_dst,
    input  logic [RC_W-1:0]                  retire_cnt,
    input  logic                             flush,
    output logic                             rob_empty,
    output logic                             rob_full,
    output logic                             occ_underflow,
    output logic [31:0]                      stall_cycles
);

    localparam int unsigned REQ_W = $clog2(DISPATCH_WIDTH + 1);
    localparam logic [IDX_W-1:0] COL_MASK = IDX_W'(DISPATCH_WIDTH - 1);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  head, tail, head_n, tail_n;
    logic [CNT_W-1:0]  occ, occ_n, free, occ_sum;
    logic              uf_n;
    logic [REQ_W-1:0]  req_cnt, accepted;
    logic [RC_W-1:0]   retire_eff;
    logic              req_fits, run_seen;

    logic [IDX_W-1:0]  lane_idx [DISPATCH_WIDTH];
    logic [DISPATCH_WIDTH-1:0] wr_en;
    logic [IDX_W-1:0]  wr_idx [DISPATCH_WIDTH];
    logic [AREG_W-1:0] wr_dst [DISPATCH_WIDTH];
    logic              wr_has [DISPATCH_WIDTH];

    // Only the unbroken run of valid lanes starting at lane 0 is requested.
    always_comb begin
        req_cnt  = '0;
        run_seen = 1'b1;
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            if (run_seen && disp_valid[i]) req_cnt = REQ_W'(i + 1);
            else                           run_seen = 1'b0;
        end
    end

    always_comb begin
        free     = CNT_W'(NUM_ROB_ENTS) - occ;
        req_fits = CNT_W'(req_cnt) <= free;
    end

    always_comb begin
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            lane_idx[i]                  = tail + IDX_W'(i);
            alloc_idx[i*IDX_W +: IDX_W]  = lane_idx[i];
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        if (flush)                 state_next = RECOVER;
        else if (state == RECOVER) state_next = RUN;
    end

    // FSM: outputs
    always_comb begin
        disp_ready = (state == RUN) && !flush && req_fits;
        accepted   = disp_ready ? req_cnt : '0;
        retire_eff = (state == RUN) ? retire_cnt : '0;
    end

    always_comb begin
        head_n  = head;
        tail_n  = tail;
        occ_n   = occ;
        uf_n    = occ_underflow;
        occ_sum = occ + CNT_W'(accepted);
        if (flush) begin
            head_n = head + IDX_W'(retire_eff);
            tail_n = head + IDX_W'(retire_eff);
            occ_n  = '0;
        end else if (state == RUN) begin
            tail_n = tail + IDX_W'(accepted);
            // Over-retire: drop everything old and keep only this cycle's group.
            if (CNT_W'(retire_cnt) > occ_sum) begin
                occ_n  = CNT_W'(accepted);
                head_n = tail;
                uf_n   = 1'b1;
            end else begin
                occ_n  = occ_sum - CNT_W'(retire_cnt);
                head_n = head + IDX_W'(retire_cnt);
            end
        end
    end

    // Consecutive lanes land in distinct columns, so each column has at most one writer.
    always_comb begin
        wr_en = '0;
        for (int unsigned c = 0; c < DISPATCH_WIDTH; c++) begin
            wr_idx[c] = '0;
            wr_dst[c] = '0;
            wr_has[c] = 1'b0;
            for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
                if ((REQ_W'(i) < accepted) && ((lane_idx[i] & COL_MASK) == IDX_W'(c))) begin
                    wr_en[c]  = 1'b1;
                    wr_idx[c] = lane_idx[i];
                    wr_dst[c] = disp_dst_reg[i*AREG_W +: AREG_W];
                    wr_has[c] = disp_has_dst[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            occ           <= '0;
            occ_underflow <= 1'b0;
            rob_empty     <= 1'b1;
            rob_full      <= 1'b0;
        end else begin
            head          <= head_n;
            tail          <= tail_n;
            occ           <= occ_n;
            occ_underflow <= uf_n;
            rob_empty     <= (occ_n == '0);
            rob_full      <= (occ_n == CNT_W'(NUM_ROB_ENTS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rob_w_en      <= '0;
            rob_w_idx     <= '0;
            rob_w_dst     <= '0;
            rob_w_has_dst <= '0;
        end else begin
            rob_w_en <= wr_en;
            for (int unsigned c = 0; c < DISPATCH_WIDTH; c++) begin
                if (wr_en[c]) begin
                    rob_w_idx[c*IDX_W +: IDX_W]   <= wr_idx[c];
                    rob_w_dst[c*AREG_W +: AREG_W] <= wr_dst[c];
                    rob_w_has_dst[c]              <= wr_has[c];
                end
            end
        end
    end

`ifdef ROB_ALLOC_STALL_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if ((req_cnt != '0) && !disp_ready && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rob_alloc.sv
// Randomized + directed bench for rob_alloc against an integer-level ROB model.
// Define ROB_ALLOC_STALL_STATS_EN here as well as in the RTL to check the stall counter.
module tb_rob_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  disp_valid;
    logic [19:0] disp_dst_reg;
    logic [3:0]  disp_has_dst;
    logic        disp_ready;
    logic [23:0] alloc_idx;
    logic [3:0]  rob_w_en;
    logic [23:0] rob_w_idx;
    logic [19:0] rob_w_dst;
    logic [3:0]  rob_w_has_dst;
    logic [2:0]  retire_cnt;
    logic        flush;
    logic        rob_empty;
    logic        rob_full;
    logic        occ_underflow;
    logic [31:0] stall_cycles;

    rob_alloc #(
        .NUM_ROB_ENTS  (64),
        .DISPATCH_WIDTH(4),
        .RETIRE_WIDTH  (4),
        .AREG_W        (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_dst_reg (disp_dst_reg),
        .disp_has_dst (disp_has_dst),
        .disp_ready   (disp_ready),
        .alloc_idx    (alloc_idx),
        .rob_w_en     (rob_w_en),
        .rob_w_idx    (rob_w_idx),
        .rob_w_dst    (rob_w_dst),
        .rob_w_has_dst(rob_w_has_dst),
        .retire_cnt   (retire_cnt),
        .flush        (flush),
        .rob_empty    (rob_empty),
        .rob_full     (rob_full),
        .occ_underflow(occ_underflow),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference ROB state, kept as plain integers.
    int      m_head, m_tail, m_occ;
    bit      m_rec, m_uf, m_valid;
    longint  m_stall;
    bit [3:0] m_en;
    int      m_widx [4];
    int      m_wdst [4];
    bit      m_whas [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs();
        check("rob_w_en", 64'(rob_w_en), 64'(m_en));
        for (int c = 0; c < 4; c++) begin
            check("rob_w_idx", 64'(rob_w_idx[c*6 +: 6]), 64'(m_widx[c]));
            check("rob_w_dst", 64'(rob_w_dst[c*5 +: 5]), 64'(m_wdst[c]));
            check("rob_w_has", 64'(rob_w_has_dst[c]), 64'(m_whas[c]));
        end
        check("rob_empty", 64'(rob_empty), 64'(m_occ == 0));
        check("rob_full", 64'(rob_full), 64'(m_occ == 64));
        check("occ_underflow", 64'(occ_underflow), 64'(m_uf));
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    endtask

    // One clock cycle: check last edge's registers, apply inputs, check
    // combinational outputs, then advance the model across the coming edge.
    task automatic cyc(input bit r, input bit [3:0] v, input bit [19:0] d,
                       input bit [3:0] h, input bit [2:0] rc, input bit f);
        int rq, free, acc, rr, col;
        bit rdy, run;
        @(negedge clk);
        if (m_valid) check_regs();
        rst = r; disp_valid = v; disp_dst_reg = d; disp_has_dst = h;
        retire_cnt = rc; flush = f;
        #1;
        rq = 0; run = 1;
        for (int i = 0; i < 4; i++) begin
            if (run && v[i]) rq = i + 1;
            else run = 0;
        end
        free = 64 - m_occ;
        rdy  = !m_rec && !f && (rq <= free);
        if (!r && m_valid) begin
            check("disp_ready", 64'(disp_ready), 64'(rdy));
            for (int i = 0; i < rq; i++)
                check("alloc_idx", 64'(alloc_idx[i*6 +: 6]), 64'((m_tail + i) % 64));
        end
        if (r) begin
            m_head = 0; m_tail = 0; m_occ = 0; m_rec = 0; m_uf = 0; m_stall = 0;
            m_en = '0;
            for (int c = 0; c < 4; c++) begin
                m_widx[c] = 0; m_wdst[c] = 0; m_whas[c] = 0;
            end
            m_valid = 1;
        end else begin
            m_en = '0;
            if (rdy) begin
                for (int i = 0; i < rq; i++) begin
                    col = (m_tail + i) % 4;
                    m_en[col]   = 1;
                    m_widx[col] = (m_tail + i) % 64;
                    m_wdst[col] = int'(d[i*5 +: 5]);
                    m_whas[col] = h[i];
                end
            end
`ifdef ROB_ALLOC_STALL_STATS_EN
            if (rq > 0 && !rdy && m_stall < 64'hffff_ffff) m_stall++;
`endif
            if (f) begin
                rr = m_rec ? 0 : int'(rc);
                m_head = (m_head + rr) % 64;
                m_tail = m_head;
                m_occ  = 0;
                m_rec  = 1;
            end else if (m_rec) begin
                m_rec = 0;
            end else begin
                acc = rdy ? rq : 0;
                if (int'(rc) > m_occ + acc) begin
                    m_occ  = acc;
                    m_head = m_tail;
                    m_uf   = 1;
                end else begin
                    m_head = (m_head + int'(rc)) % 64;
                    m_occ  = m_occ + acc - int'(rc);
                end
                m_tail = (m_tail + acc) % 64;
            end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    localparam bit [19:0] DST1234 = {5'd4, 5'd3, 5'd2, 5'd1};

    initial begin
        bit [3:0] v;
        bit [2:0] rc;
        bit f, r;
        m_valid = 0;
        rst = 1; disp_valid = 0; disp_dst_reg = 0; disp_has_dst = 0; retire_cnt = 0; flush = 0;

        // First group after reset
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 4'b1111, DST1234, 4'b1111, 0, 0);
        check("tp1_ready", 64'(disp_ready), 64'd1);
        check("tp1_idx3", 64'(alloc_idx[18 +: 6]), 64'd3);
        settle();
        check("tp1_wen", 64'(rob_w_en), 64'hf);
        check("tp1_wdst", 64'(rob_w_dst), 64'(DST1234));
        check("tp1_empty", 64'(rob_empty), 64'd0);

        // Gapped valid mask at tail = 6
        cyc(0, 4'b0011, 20'h12345, 4'b0101, 0, 0);
        cyc(0, 4'b1011, 20'h0abcd, 4'b1010, 0, 0);
        check("tp2_idx0", 64'(alloc_idx[0 +: 6]), 64'd6);
        check("tp2_idx1", 64'(alloc_idx[6 +: 6]), 64'd7);
        settle();
        check("tp2_wen", 64'(rob_w_en), 64'b1100);

        // Fill to 62, blocked request with retire, then wrap-around accept
        for (int k = 0; k < 13; k++) cyc(0, 4'b1111, 20'($urandom), 4'($urandom), 0, 0);
        cyc(0, 4'b0011, 20'($urandom), 4'($urandom), 0, 0);
        cyc(0, 4'b1111, DST1234, 4'b1111, 2, 0);
        check("tp3_blocked", 64'(disp_ready), 64'd0);
        cyc(0, 4'b1111, DST1234, 4'b1111, 0, 0);
        check("tp3_ready", 64'(disp_ready), 64'd1);
        check("tp4_idx0", 64'(alloc_idx[0 +: 6]), 64'd62);
        check("tp4_idx2", 64'(alloc_idx[12 +: 6]), 64'd0);
        check("tp4_idx3", 64'(alloc_idx[18 +: 6]), 64'd1);
        settle();
        check("tp3_full", 64'(rob_full), 64'd1);
`ifdef ROB_ALLOC_STALL_STATS_EN
        check("tp3_stall", 64'(stall_cycles), 64'd1);
`endif
        cyc(0, 4'b0001, 0, 0, 0, 0);
        check("tp4_tail", 64'(alloc_idx[0 +: 6]), 64'd2);

        // Flush with retire and a pending request
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 4'b1111, 20'($urandom), 4'($urandom), 0, 0);
        cyc(0, 4'b0111, 20'($urandom), 4'($urandom), 0, 0);
        cyc(0, 0, 0, 0, 4, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 4'b1111, DST1234, 4'b1111, 3, 1);
        check("tp5_flush_ready", 64'(disp_ready), 64'd0);
        cyc(0, 4'b1111, DST1234, 4'b1111, 2, 0);
        check("tp5_recover", 64'(disp_ready), 64'd0);
        cyc(0, 4'b1111, DST1234, 4'b1111, 0, 0);
        check("tp5_run", 64'(disp_ready), 64'd1);
        check("tp5_idx0", 64'(alloc_idx[0 +: 6]), 64'd8);

        // Over-retire sets the sticky underflow flag
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 4'b0001, 5'd9, 1, 0, 0);
        cyc(0, 0, 0, 0, 3, 0);
        settle();
        check("tp6_uf", 64'(occ_underflow), 64'd1);
        check("tp6_empty", 64'(rob_empty), 64'd1);
        for (int k = 0; k < 3; k++) cyc(0, 4'b0011, 20'($urandom), 4'($urandom), 0, 0);
        settle();
        check("tp6_uf_sticky", 64'(occ_underflow), 64'd1);

        // Random traffic, including mid-run resets and flushes
        cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 299) == 0);
            f  = ($urandom_range(0, 24) == 0);
            v  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) v = 4'b1111;
            rc = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) rc = 0;
            if (m_rec && f) rc = 0;
            cyc(r, v, 20'($urandom), 4'($urandom), rc, f);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
